// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing/divisor constants.
// Used by the receive sequencer and the baud counter it shares with the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uartState_t;

    localparam int DATA_BITS   = 8;
    localparam int DEFAULT_DIV = 868;
    localparam int MIN_DIV     = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Baud tick generator: counts clocks since the last clear and flags the
// half-bit and full-bit points for a clocks-per-bit divisor.
module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             bitPt,
    output logic             halfPt
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

    assign bitPt  = (cnt == div - DIV_W'(1));
    assign halfPt = (cnt == (div >> 1) - DIV_W'(1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, samples each bit at mid-point, checks
// framing and hands bytes to a valid/ready consumer. UART_RX_PARITY_EN adds even parity.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              cfg_we,
    input  logic [DIV_W-1:0]  cfg_div,
    uart_rx_ctrl_if.master    bus,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              parity_err
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxMeta;
    logic                 rxS;
    uartState_t           state;
    logic [DIV_W-1:0]     div;
    logic                 armed;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] dataOut;
    logic                 dataValid;
    logic                 bitPt;
    logic                 halfPt;
    logic                 cntClr;
`ifdef UART_RX_PARITY_EN
    logic                 parityBit;
    logic                 parityErr;
`endif

    // NOTE: non-blocking assignments let rxS read the old rxMeta, forming two real flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
        end
    end

    // NOTE: the default arm assigns cntClr on every path, so no latch is inferred.
    always_comb begin
        case (state)
            START:              cntClr = halfPt;
            DATA, PARITY, STOP: cntClr = bitPt;
            default:            cntClr = 1'b1;
        endcase
    end

    uart_baud_cnt #(.DIV_W(DIV_W)) baudCnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cntClr),
        .div    (div),
        .bitPt  (bitPt),
        .halfPt (halfPt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div         <= DIV_W'(DEFAULT_DIV);
            armed       <= 1'b0;
            idx         <= '0;
            shiftReg    <= '0;
            dataOut     <= '0;
            dataValid   <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit   <= 1'b0;
            parityErr   <= 1'b0;
`endif
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr   <= 1'b0;
`endif
            if (dataValid && bus.data_ready)
                dataValid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_we)
                        div <= (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
                    // A stuck-low line must be released high before the next start is taken.
                    if (rxS)
                        armed <= 1'b1;
                    else if (armed) begin
                        armed <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (halfPt) begin
                        if (rxS)
                            state <= IDLE;
                        else begin
                            idx   <= '0;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bitPt) begin
                        shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                        idx      <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bitPt) begin
                        parityBit <= rxS;
                        state     <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bitPt) begin
                        state <= IDLE;
                        if (!rxS)
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        else if (^{shiftReg, parityBit})
                            parityErr <= 1'b1;
`endif
                        else if (!dataValid || bus.data_ready) begin
                            dataOut   <= shiftReg;
                            dataValid <= 1'b1;
                        end else
                            overrun_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign bus.data_out   = dataOut;
    assign bus.data_valid = dataValid;
`ifdef UART_RX_PARITY_EN
    assign parity_err     = parityErr;
`else
    assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomised frames
// checked against a holding-register model. Define UART_RX_PARITY_EN to cover parity.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx;
    logic             cfg_we;
    logic [DIV_W-1:0] cfg_div;
    logic             busy;
    logic             frame_err;
    logic             overrun_err;
    logic             parity_err;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(868)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .cfg_we      (cfg_we),
        .cfg_div     (cfg_div),
        .bus         (bus),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int curDiv      = DEFAULT_DIV;

    // Monitor: pulse-cycle counters and accepted bytes, sampled just after the falling edge.
    int          frameErrCnt  = 0;
    int          overrunCnt   = 0;
    int          parityErrCnt = 0;
    int          bothErrCnt   = 0;
    byte unsigned acceptedQ[$];

    always @(negedge clk) begin
        #1;
        if (rst === 1'b0) begin
            if (frame_err)   frameErrCnt++;
            if (overrun_err) overrunCnt++;
            if (parity_err)  parityErrCnt++;
            if (frame_err && parity_err) bothErrCnt++;
            if (bus.data_valid && bus.data_ready) acceptedQ.push_back(bus.data_out);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfgWrite(input int v);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_div = DIV_W'(v);
        @(negedge clk);
        cfg_we  = 1'b0;
        curDiv  = (v < MIN_DIV) ? MIN_DIV : v;
    endtask

    // Drives one frame, each bit held d cycles; endHigh releases the line afterwards.
    task automatic sendFrame(input byte unsigned b, input bit stopBit, input bit parFlip,
                             input int d, input bit endHigh);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back((^b) ^ parFlip);
`else
        if (parFlip) bits.push_back(1'b1);
`endif
        bits.push_back(stopBit);
        @(negedge clk);
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (d) @(negedge clk);
        end
        if (endHigh) begin
            rx = 1'b1;
            repeat (4) @(negedge clk);
        end
        #2;
    endtask

    task automatic drain();
        @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        byte unsigned b;
        rst = 1'b1; rx = 1'b1; cfg_we = 1'b0; cfg_div = '0; bus.data_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        vectors++;
        if ({bus.data_out, bus.data_valid, busy} !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got out=%h valid=%b busy=%b required 00/0/0",
                     bus.data_out, bus.data_valid, busy);
        end
        vectors++;
        if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_errors: got %b required 000", {frame_err, overrun_err, parity_err});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        // Frame at the reset divisor proves DEFAULT_DIV was loaded.
        b = byte'($urandom);
        curDiv = DEFAULT_DIV;
        sendFrame(b, 1'b1, 1'b0, curDiv, 1'b1);
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== b) begin
            miscompares++;
            $display("FAIL default_div: got valid=%b out=%h required 1/%h", bus.data_valid, bus.data_out, b);
        end
        drain();
    endtask

    task automatic test_basic();
        int lat = 0;
        int fe0 = frameErrCnt, ov0 = overrunCnt, pe0 = parityErrCnt;
        cfgWrite(16);
        fork
            sendFrame(8'hA5, 1'b1, 1'b0, curDiv, 1'b1);
            begin
                @(negedge clk);
                while (bus.data_valid !== 1'b1 && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        vectors++;
        if (lat < 151 || lat > 159) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles required about 155", lat);
        end
        vectors++;
        if (bus.data_out !== 8'hA5 || bus.data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_data: got %h/%b required a5/1", bus.data_out, bus.data_valid);
        end
        vectors++;
        if (frameErrCnt != fe0 || overrunCnt != ov0 || parityErrCnt != pe0) begin
            miscompares++;
            $display("FAIL basic_errors: got fe=%0d ov=%0d pe=%0d new pulses required none",
                     frameErrCnt - fe0, overrunCnt - ov0, parityErrCnt - pe0);
        end
        drain();
    endtask

    task automatic test_glitch();
        int fe0 = frameErrCnt;
        int ov0 = overrunCnt;
        logic busyMid;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        #2;
        busyMid = busy;
        repeat (30) @(negedge clk);
        #2;
        vectors++;
        if (busyMid !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy_mid: got %b required 1", busyMid);
        end
        vectors++;
        if (busy !== 1'b0 || bus.data_valid !== 1'b0 || frameErrCnt != fe0 || overrunCnt != ov0) begin
            miscompares++;
            $display("FAIL glitch_abort: got busy=%b valid=%b fe=%0d ov=%0d required 0/0/0/0",
                     busy, bus.data_valid, frameErrCnt - fe0, overrunCnt - ov0);
        end
    endtask

    task automatic test_frame_err();
        int fe0 = frameErrCnt;
        int busyCycles = 0;
        sendFrame(8'h3C, 1'b0, 1'b0, curDiv, 1'b0);
        vectors++;
        if (frameErrCnt - fe0 != 1 || bus.data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err_pulse: got %0d pulse cycles valid=%b required 1/0",
                     frameErrCnt - fe0, bus.data_valid);
        end
        for (int i = 0; i < 40 * curDiv; i++) begin
            @(negedge clk);
            #2;
            if (busy) busyCycles++;
        end
        vectors++;
        if (busyCycles != 0 || frameErrCnt - fe0 != 1) begin
            miscompares++;
            $display("FAIL stuck_low: got %0d busy cycles, %0d frame_err cycles required 0/1",
                     busyCycles, frameErrCnt - fe0);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        sendFrame(8'hC3, 1'b1, 1'b0, curDiv, 1'b1);
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hC3) begin
            miscompares++;
            $display("FAIL after_break: got %b/%h required 1/c3", bus.data_valid, bus.data_out);
        end
        drain();
    endtask

    task automatic test_overrun();
        int ov0 = overrunCnt;
        int acc0;
        // Stop sample falls 9.5 bit times plus two synchroniser cycles after the start edge.
        int stopOff = 9 * curDiv + curDiv / 2 + 2;
        bus.data_ready = 1'b0;
        sendFrame(8'h11, 1'b1, 1'b0, curDiv, 1'b1);
        sendFrame(8'h22, 1'b1, 1'b0, curDiv, 1'b1);
        vectors++;
        if (bus.data_out !== 8'h11 || bus.data_valid !== 1'b1 || overrunCnt - ov0 != 1) begin
            miscompares++;
            $display("FAIL overrun: got out=%h valid=%b ov=%0d required 11/1/1",
                     bus.data_out, bus.data_valid, overrunCnt - ov0);
        end
        acc0 = acceptedQ.size();
        fork
            sendFrame(8'h33, 1'b1, 1'b0, curDiv, 1'b1);
            begin
                @(negedge clk);
                repeat (stopOff) @(negedge clk);
                bus.data_ready = 1'b1;
                @(negedge clk);
                bus.data_ready = 1'b0;
            end
        join
        vectors++;
        if (bus.data_out !== 8'h33 || bus.data_valid !== 1'b1 || overrunCnt - ov0 != 1) begin
            miscompares++;
            $display("FAIL coincident_accept: got out=%h valid=%b ov=%0d required 33/1/1",
                     bus.data_out, bus.data_valid, overrunCnt - ov0);
        end
        vectors++;
        if (acceptedQ.size() != acc0 + 1 || acceptedQ[acceptedQ.size() - 1] !== 8'h11) begin
            miscompares++;
            $display("FAIL coincident_consumed: got %0d accepts required 1 of byte 11",
                     acceptedQ.size() - acc0);
        end
        drain();
        vectors++;
        if (acceptedQ[acceptedQ.size() - 1] !== 8'h33 || bus.data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_33: got %h valid=%b required 33/0",
                     acceptedQ[acceptedQ.size() - 1], bus.data_valid);
        end
    endtask

    task automatic test_cfg();
        byte unsigned b;
        b = byte'($urandom);
        fork
            sendFrame(b, 1'b1, 1'b0, 16, 1'b1);
            begin
                repeat (40) @(negedge clk);
                cfg_we  = 1'b1;
                cfg_div = DIV_W'(8);
                @(negedge clk);
                cfg_we  = 1'b0;
            end
        join
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== b) begin
            miscompares++;
            $display("FAIL cfg_busy_ignored: got %b/%h required 1/%h", bus.data_valid, bus.data_out, b);
        end
        drain();
        cfgWrite(8);
        b = byte'($urandom);
        sendFrame(b, 1'b1, 1'b0, 8, 1'b1);
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== b) begin
            miscompares++;
            $display("FAIL cfg_div8: got %b/%h required 1/%h", bus.data_valid, bus.data_out, b);
        end
        drain();
        cfgWrite(1);
        b = byte'($urandom);
        sendFrame(b, 1'b1, 1'b0, 4, 1'b1);
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== b) begin
            miscompares++;
            $display("FAIL cfg_clamp4: got %b/%h required 1/%h", bus.data_valid, bus.data_out, b);
        end
        drain();
    endtask

    task automatic test_rst_mid();
        int pe0;
        int fe0;
        logic busyBefore;
        cfgWrite(16);
        sendFrame(8'h77, 1'b1, 1'b0, curDiv, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (curDiv) @(negedge clk);
        rx = 1'b1;
        repeat (2 * curDiv + 5) @(negedge clk);
        #2;
        busyBefore = busy;
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (busyBefore !== 1'b1 || busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid: got busyBefore=%b busy=%b valid=%b out=%h required 1/0/0/00",
                     busyBefore, busy, bus.data_valid, bus.data_out);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cfgWrite(16);
        sendFrame(8'h5A, 1'b1, 1'b0, curDiv, 1'b1);
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL after_rst: got %b/%h required 1/5a", bus.data_valid, bus.data_out);
        end
        drain();
        pe0 = parityErrCnt;
        fe0 = frameErrCnt;
`ifdef UART_RX_PARITY_EN
        sendFrame(8'h5A, 1'b1, 1'b1, curDiv, 1'b1);
        vectors++;
        if (parityErrCnt - pe0 != 1 || bus.data_valid !== 1'b0 || frameErrCnt != fe0) begin
            miscompares++;
            $display("FAIL parity_err: got pe=%0d valid=%b fe=%0d required 1/0/0",
                     parityErrCnt - pe0, bus.data_valid, frameErrCnt - fe0);
        end
`else
        sendFrame(8'h5A, 1'b1, 1'b0, curDiv, 1'b1);
        vectors++;
        if (parityErrCnt != pe0 || bus.data_valid !== 1'b1 || bus.data_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL parity_off: got pe=%0d valid=%b out=%h required 0/1/5a",
                     parityErrCnt - pe0, bus.data_valid, bus.data_out);
        end
        drain();
`endif
    endtask

    // Reference model: a one-entry holding register fed by frames and drained at random.
    task automatic test_random();
        bit           mValid = 1'b0;
        byte unsigned mData  = 8'h00;
        int expFe = frameErrCnt, expOv = overrunCnt, expPe = parityErrCnt;
        for (int n = 0; n < 16; n++) begin
            byte unsigned b = byte'($urandom);
            bit stopOk = ($urandom_range(0, 4) != 0);
            bit pFlip = 1'b0;
`ifdef UART_RX_PARITY_EN
            pFlip = ($urandom_range(0, 4) == 0);
`endif
            if ($urandom_range(0, 2) == 0) cfgWrite(int'($urandom_range(1, 20)));
            if (!stopOk)      expFe++;
            else if (pFlip)   expPe++;
            else if (!mValid) begin mValid = 1'b1; mData = b; end
            else              expOv++;
            sendFrame(b, stopOk, pFlip, curDiv, 1'b1);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            #2;
            vectors++;
            if (bus.data_valid !== mValid || (mValid && bus.data_out !== mData)) begin
                miscompares++;
                $display("FAIL rand_hold[%0d]: got %b/%h required %b/%h",
                         n, bus.data_valid, bus.data_out, mValid, mData);
            end
            vectors++;
            if (frameErrCnt != expFe || overrunCnt != expOv || parityErrCnt != expPe) begin
                miscompares++;
                $display("FAIL rand_errs[%0d]: got fe=%0d ov=%0d pe=%0d required %0d/%0d/%0d",
                         n, frameErrCnt, overrunCnt, parityErrCnt, expFe, expOv, expPe);
            end
            if (mValid && $urandom_range(0, 1) == 1) begin
                drain();
                vectors++;
                if (acceptedQ[acceptedQ.size() - 1] !== mData || bus.data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_drain[%0d]: got %h valid=%b required %h/0",
                             n, acceptedQ[acceptedQ.size() - 1], bus.data_valid, mData);
                end
                mValid = 1'b0;
            end
        end
        vectors++;
        if (bothErrCnt != 0) begin
            miscompares++;
            $display("FAIL err_exclusive: got %0d overlapping cycles required 0", bothErrCnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_cfg();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
